ex_mem_flags: RTL

- Execute-to-memory pipeline stage directly downstream of the 64-bit ALU in the pipelined LEGv8 CPU.
- Holds the architectural NZVC flag register, which ADDS/SUBS update from the ALU flag outputs.
- Resolves CBZ/CBNZ/B.cond against the ALU zero flag or the stored flags.
- Registers the ALU result, branch decision and control bits into the EX/MEM latch, with stall and flush support.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/ex_mem_flags_if.sv | 50 +++++
 rtl/cond_eval.sv | 32 +++
 rtl/ex_mem_flags.sv | 98 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: condition codes, branch kinds and the packed NZVC flag word.
package cpu_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_CBZ  = 2'b01,
      BR_CBNZ = 2'b10,
      BR_COND = 2'b11
   } br_kind_e;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/ex_mem_flags_if.sv
// EX-side inputs and MEM-side latch outputs of the EX/MEM stage, with stall/flush.
interface ex_mem_flags_if #(
   parameter int DW = 64,
   parameter int RW = 5
);
   logic          stall;
   logic          flush;
   logic          ex_valid;
   logic [DW-1:0] alu_result;
   logic          alu_neg;
   logic          alu_zero;
   logic          alu_ovf;
   logic          alu_cout;
   logic          set_flags;
   logic [1:0]    br_kind;
   logic [3:0]    cond;
   logic [DW-1:0] br_target;
   logic [DW-1:0] store_data;
   logic [RW-1:0] rd;
   logic          reg_write;
   logic          mem_read;
   logic          mem_write;

   logic          mem_valid;
   logic [DW-1:0] mem_result;
   logic [DW-1:0] mem_store_data;
   logic [RW-1:0] mem_rd;
   logic          mem_reg_write;
   logic          mem_mem_read;
   logic          mem_mem_write;
   logic          mem_br_taken;
   logic [DW-1:0] mem_br_target;
   logic [3:0]    flags;

   modport master (
      output stall, flush, ex_valid, alu_result, alu_neg, alu_zero, alu_ovf, alu_cout,
             set_flags, br_kind, cond, br_target, store_data, rd,
             reg_write, mem_read, mem_write,
      input  mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_br_taken, mem_br_target, flags
   );

   modport slave (
      input  stall, flush, ex_valid, alu_result, alu_neg, alu_zero, alu_ovf, alu_cout,
             set_flags, br_kind, cond, br_target, store_data, rd,
             reg_write, mem_read, mem_write,
      output mem_valid, mem_result, mem_store_data, mem_rd, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_br_taken, mem_br_target, flags
   );
endinterface

// File: rtl/cond_eval.sv
// Evaluates a B.cond condition code against a stored NZVC flag word.
module cond_eval
   import cpu_pkg::*;
(
   input  flags_t flags,
   input  cond_e  cond,
   output logic   taken
);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      taken = 1'b1;
      case (cond)
         COND_EQ: taken =  flags.z;
         COND_NE: taken = ~flags.z;
         COND_HS: taken =  flags.c;
         COND_LO: taken = ~flags.c;
         COND_MI: taken =  flags.n;
         COND_PL: taken = ~flags.n;
         COND_VS: taken =  flags.v;
         COND_VC: taken = ~flags.v;
         COND_HI: taken =   flags.c & ~flags.z;
         COND_LS: taken = ~(flags.c & ~flags.z);
         COND_GE: taken =  (flags.n == flags.v);
         COND_LT: taken =  (flags.n != flags.v);
         COND_GT: taken =   ~flags.z & (flags.n == flags.v);
         COND_LE: taken = ~(~flags.z & (flags.n == flags.v));
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline latch with the architectural NZVC register and branch resolution.
module ex_mem_flags
   import cpu_pkg::*;
#(
   parameter int DW = 64,
   parameter int RW = 5
) (
   input logic          clk,
   input logic          reset,
   ex_mem_flags_if.slave bus
);

   flags_t        flags_q;
   logic          fire;
   logic          cond_taken;
   logic          br_taken;
   br_kind_e      kind;

   logic          valid_q;
   logic [DW-1:0] result_q;
   logic [DW-1:0] store_data_q;
   logic [RW-1:0] rd_q;
   logic          reg_write_q;
   logic          mem_read_q;
   logic          mem_write_q;
   logic          br_taken_q;
   logic [DW-1:0] br_target_q;

   assign fire = bus.ex_valid & ~bus.stall & ~bus.flush;
   assign kind = br_kind_e'(bus.br_kind);

   // B.cond always reads the stored flags; the setter has already left EX.
   cond_eval u_cond_eval (
      .flags (flags_q),
      .cond  (cond_e'(bus.cond)),
      .taken (cond_taken)
   );

   always_comb begin
      br_taken = 1'b0;
      case (kind)
         BR_CBZ:  br_taken =  bus.alu_zero;
         BR_CBNZ: br_taken = ~bus.alu_zero;
         BR_COND: br_taken =  cond_taken;
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         flags_q      <= '0;
         valid_q      <= 1'b0;
         result_q     <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         br_taken_q   <= 1'b0;
         br_target_q  <= '0;
      end else if (!bus.stall) begin
         if (bus.flush) begin
            // Bubble: kill side effects, data fields simply hold.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            br_taken_q  <= 1'b0;
         end else begin
            valid_q      <= bus.ex_valid;
            result_q     <= bus.alu_result;
            store_data_q <= bus.store_data;
            rd_q         <= bus.rd;
            reg_write_q  <= bus.ex_valid & bus.reg_write;
            mem_read_q   <= bus.ex_valid & bus.mem_read;
            mem_write_q  <= bus.ex_valid & bus.mem_write;
            br_taken_q   <= bus.ex_valid & br_taken;
            br_target_q  <= bus.br_target;
         end
         if (fire && bus.set_flags) begin
            flags_q <= '{n: bus.alu_neg, z: bus.alu_zero, v: bus.alu_ovf, c: bus.alu_cout};
         end
      end
   end

   assign bus.mem_valid      = valid_q;
   assign bus.mem_result     = result_q;
   assign bus.mem_store_data = store_data_q;
   assign bus.mem_rd         = rd_q;
   assign bus.mem_reg_write  = reg_write_q;
   assign bus.mem_mem_read   = mem_read_q;
   assign bus.mem_mem_write  = mem_write_q;
   assign bus.mem_br_taken   = br_taken_q;
   assign bus.mem_br_target  = br_target_q;
   assign bus.flags          = flags_q;

endmodule
